// File: rtl/conv2d_pkg.sv
// Shared types and elaboration-time helpers for the dilated conv2d window feeder.
package conv2d_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2, never below 1 so single-value counters still get a bit.
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Output extent of a stride-1 dilated, padded convolution along one axis.
  function automatic int out_dim(input int in_dim, input int pad, input int dil, input int k);
    return in_dim + 2 * pad - dil * (k - 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv2d_tap_addr_gen.sv
// Walks oy/ox/ky/kx in raster-of-windows order and maps each tap to a source pixel or padding.
module conv2d_tap_addr_gen
  import conv2d_pkg::*;
#(
  parameter int H     = 8,
  parameter int KH    = 3,
  parameter int KW    = 5,
  parameter int PAD_H = 2,
  parameter int PAD_W = 4,
  parameter int DIL_H = 2,
  parameter int DIL_W = 3,
  parameter int AW    = clog2_min1(H),
  parameter int KYW   = clog2_min1(KH),
  parameter int KXW   = clog2_min1(KW)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           adv_i,
  output logic [AW-1:0]  iy_o,
  output logic [AW-1:0]  ix_o,
  output logic [KYW-1:0] ky_o,
  output logic [KXW-1:0] kx_o,
  output logic           pad_o,
  output logic           last_o,
  output logic           final_o
);

  localparam int OH  = out_dim(H, PAD_H, DIL_H, KH);
  localparam int OW  = out_dim(H, PAD_W, DIL_W, KW);
  localparam int OYW = clog2_min1(OH);
  localparam int OXW = clog2_min1(OW);
  localparam int SW  = clog2_min1(H + 2 * max_int(PAD_H, PAD_W)) + 2;

  localparam logic [OYW-1:0]      OY_LAST = OYW'(OH - 1);
  localparam logic [OXW-1:0]      OX_LAST = OXW'(OW - 1);
  localparam logic [KYW-1:0]      KY_LAST = KYW'(KH - 1);
  localparam logic [KXW-1:0]      KX_LAST = KXW'(KW - 1);
  localparam logic signed [SW-1:0] H_S    = SW'(H);

  logic [OYW-1:0] oy_q, oy_d;
  logic [OXW-1:0] ox_q, ox_d;
  logic [KYW-1:0] ky_q, ky_d;
  logic [KXW-1:0] kx_q, kx_d;
  logic signed [SW-1:0] iy_s, ix_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oy_q <= '0;
      ox_q <= '0;
      ky_q <= '0;
      kx_q <= '0;
    end else begin
      oy_q <= oy_d;
      ox_q <= ox_d;
      ky_q <= ky_d;
      kx_q <= kx_d;
    end
  end

  // kx is innermost; the final advance wraps everything back to the first tap.
  always_comb begin
    oy_d = oy_q;
    ox_d = ox_q;
    ky_d = ky_q;
    kx_d = kx_q;
    if (adv_i) begin
      if (kx_q == KX_LAST) begin
        kx_d = '0;
        if (ky_q == KY_LAST) begin
          ky_d = '0;
          if (ox_q == OX_LAST) begin
            ox_d = '0;
            oy_d = (oy_q == OY_LAST) ? '0 : oy_q + OYW'(1);
          end else begin
            ox_d = ox_q + OXW'(1);
          end
        end else begin
          ky_d = ky_q + KYW'(1);
        end
      end else begin
        kx_d = kx_q + KXW'(1);
      end
    end
  end

  // SW leaves room for the sign, so negative indices show up as a set MSB.
  always_comb begin
    iy_s = $signed(SW'(oy_q) + SW'(ky_q) * SW'(DIL_H) - SW'(PAD_H));
    ix_s = $signed(SW'(ox_q) + SW'(kx_q) * SW'(DIL_W) - SW'(PAD_W));
  end

  assign pad_o   = iy_s[SW-1] || (iy_s >= H_S) || ix_s[SW-1] || (ix_s >= H_S);
  assign iy_o    = iy_s[AW-1:0];
  assign ix_o    = ix_s[AW-1:0];
  assign ky_o    = ky_q;
  assign kx_o    = kx_q;
  assign last_o  = (ky_q == KY_LAST) && (kx_q == KX_LAST);
  assign final_o = last_o && (oy_q == OY_LAST) && (ox_q == OX_LAST);

endmodule

// File: rtl/conv2d_dilated_window_feeder.sv
// Buffers one HxH frame and a KHxKW weight set, then streams every (pixel, weight) tap per output position.
module conv2d_dilated_window_feeder
  import conv2d_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int H      = 8,
  parameter int KH     = 3,
  parameter int KW     = 5,
  parameter int PAD_H  = 2,
  parameter int PAD_W  = 4,
  parameter int DIL_H  = 2,
  parameter int DIL_W  = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [DATA_W-1:0]             pix_data,
  input  logic                          wgt_we,
  input  logic [clog2_min1(KH*KW)-1:0]  wgt_addr,
  input  logic [DATA_W-1:0]             wgt_data,
  output logic                          tap_valid,
  input  logic                          tap_ready,
  output logic [DATA_W-1:0]             input_data,
  output logic [DATA_W-1:0]             weight_data,
  output logic                          tap_last,
  output logic                          frame_done,
  output state_e                        dbg_state_o
);

  localparam int OH  = out_dim(H, PAD_H, DIL_H, KH);
  localparam int OW  = out_dim(H, PAD_W, DIL_W, KW);
  localparam int AW  = clog2_min1(H);
  localparam int KYW = clog2_min1(KH);
  localparam int KXW = clog2_min1(KW);
  localparam int WAW = clog2_min1(KH * KW);

  if (OH < 1 || OW < 1) begin : g_bad_geometry
    $error("conv2d_dilated_window_feeder: kernel span exceeds padded input");
  end

  state_e state_q, state_d;

  logic [DATA_W-1:0] frame_mem [H][H];
  logic [DATA_W-1:0] wgt_mem [KH*KW];

  logic [AW-1:0]     px_x_q, px_y_q;
  logic              tap_valid_q, tap_last_q, tap_final_q, issued_final_q;
  logic [DATA_W-1:0] input_data_q, weight_data_q;

  logic              load_en, accept, pix_fire;
  logic [AW-1:0]     iy, ix;
  logic [KYW-1:0]    ky;
  logic [KXW-1:0]    kx;
  logic              pad, last, final_tap;
  logic [WAW-1:0]    w_idx;

  conv2d_tap_addr_gen #(
    .H(H), .KH(KH), .KW(KW), .PAD_H(PAD_H), .PAD_W(PAD_W), .DIL_H(DIL_H), .DIL_W(DIL_W),
    .AW(AW), .KYW(KYW), .KXW(KXW)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv_i   (load_en),
    .iy_o    (iy),
    .ix_o    (ix),
    .ky_o    (ky),
    .kx_o    (kx),
    .pad_o   (pad),
    .last_o  (last),
    .final_o (final_tap)
  );

  // Handshake: a tap transfers on a clock edge where tap_valid && tap_ready. The output
  // register reloads only when empty or transferring, so a stalled tap holds all fields.
  assign accept   = tap_valid_q && tap_ready;
  assign load_en  = (state_q == ST_EMIT) && !issued_final_q && (!tap_valid_q || tap_ready);
  assign pix_fire = pix_valid && (state_q == ST_LOAD);
  assign w_idx    = WAW'(ky) * WAW'(KW) + WAW'(kx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pix_ready  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_LOAD: begin
        pix_ready = 1'b1;
        if (pix_fire && px_x_q == AW'(H - 1) && px_y_q == AW'(H - 1)) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (accept && tap_final_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_x_q <= '0;
      px_y_q <= '0;
    end else if (pix_fire) begin
      if (px_x_q == AW'(H - 1)) begin
        px_x_q <= '0;
        px_y_q <= (px_y_q == AW'(H - 1)) ? '0 : px_y_q + AW'(1);
      end else begin
        px_x_q <= px_x_q + AW'(1);
      end
    end
  end

  // Storage arrays carry no reset; weights must be rewritten after rst_n.
  always_ff @(posedge clk) begin
    if (pix_fire) frame_mem[px_y_q][px_x_q] <= pix_data;
    if (wgt_we && state_q != ST_EMIT && int'(wgt_addr) < KH * KW) wgt_mem[wgt_addr] <= wgt_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_valid_q    <= 1'b0;
      tap_last_q     <= 1'b0;
      tap_final_q    <= 1'b0;
      issued_final_q <= 1'b0;
      input_data_q   <= '0;
      weight_data_q  <= '0;
    end else begin
      if (load_en) begin
        tap_valid_q   <= 1'b1;
        tap_last_q    <= last;
        tap_final_q   <= final_tap;
        input_data_q  <= pad ? '0 : frame_mem[iy][ix];
        weight_data_q <= wgt_mem[w_idx];
      end else if (accept) begin
        tap_valid_q <= 1'b0;
      end
      if (load_en && final_tap)  issued_final_q <= 1'b1;
      else if (state_q == ST_DONE) issued_final_q <= 1'b0;
    end
  end

  assign tap_valid   = tap_valid_q;
  assign tap_last    = tap_last_q;
  assign input_data  = input_data_q;
  assign weight_data = weight_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_conv2d_dilated_window_feeder.sv
// Scoreboard bench for the dilated window feeder: a reference tap model fills exp_q per loaded frame.
module tb_conv2d_dilated_window_feeder;
  import conv2d_pkg::*;

  localparam int DATA_W = 32;
  localparam int H      = 8;
  localparam int KH     = 3;
  localparam int KW     = 5;
  localparam int PAD_H  = 2;
  localparam int PAD_W  = 4;
  localparam int DIL_H  = 2;
  localparam int DIL_W  = 3;
  localparam int OH     = 8;
  localparam int OW     = 4;
  localparam int TAPS   = OH * OW * KH * KW;
  localparam int NWIN   = OH * OW;
  localparam int EW     = 2 * DATA_W + 1;
  localparam int BUDGET = 6000;

  logic              clk;
  logic              rst_n;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic              wgt_we;
  logic [3:0]        wgt_addr;
  logic [DATA_W-1:0] wgt_data;
  logic              tap_valid;
  logic              tap_ready;
  logic [DATA_W-1:0] input_data;
  logic [DATA_W-1:0] weight_data;
  logic              tap_last;
  logic              frame_done;
  state_e            dbg_state;

  int total;
  int bad;

  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] pix_m [H*H];
  logic [DATA_W-1:0] wgt_m [KH*KW];
  logic [EW-1:0]     obs_first [KH*KW];

  conv2d_dilated_window_feeder #(
    .DATA_W(DATA_W), .H(H), .KH(KH), .KW(KW),
    .PAD_H(PAD_H), .PAD_W(PAD_W), .DIL_H(DIL_H), .DIL_W(DIL_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .wgt_we      (wgt_we),
    .wgt_addr    (wgt_addr),
    .wgt_data    (wgt_data),
    .tap_valid   (tap_valid),
    .tap_ready   (tap_ready),
    .input_data  (input_data),
    .weight_data (weight_data),
    .tap_last    (tap_last),
    .frame_done  (frame_done),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one expected {last, pixel, weight} entry per tap, in emission order.
  task automatic push_expected();
    int iy, ix;
    logic [DATA_W-1:0] d;
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++)
        for (int ky = 0; ky < KH; ky++)
          for (int kx = 0; kx < KW; kx++) begin
            iy = oy + ky * DIL_H - PAD_H;
            ix = ox + kx * DIL_W - PAD_W;
            if (iy >= 0 && iy < H && ix >= 0 && ix < H) d = pix_m[iy * H + ix];
            else d = '0;
            exp_q.push_back({(ky == KH - 1 && kx == KW - 1), d, wgt_m[ky * KW + kx]});
          end
  endtask

  // Drivers
  task automatic load_weights(input bit rnd);
    @(posedge clk); #1;
    for (int a = 0; a < KH * KW; a++) begin
      wgt_m[a] = rnd ? $urandom() : DATA_W'(5 * (a / KW) + (a % KW) + 1);
      wgt_we   = 1'b1;
      wgt_addr = 4'(a);
      wgt_data = wgt_m[a];
      @(posedge clk); #1;
    end
    wgt_we = 1'b0;
  endtask

  task automatic load_frame(input bit rnd);
    @(posedge clk); #1;
    for (int i = 0; i < H * H; i++) begin
      pix_m[i]  = rnd ? $urandom() : DATA_W'(8 * (i / H) + (i % H) + 1);
      pix_valid = 1'b1;
      pix_data  = pix_m[i];
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    push_expected();
  endtask

  // Consumes taps against exp_q; also checks that a stalled tap holds its fields.
  task automatic collect(input int ready_pct, input int stall_at, input int stall_len,
                         input int stop_at, input bit poke,
                         output int n_taps, output int n_last, output int n_done);
    int stall_left;
    bit stall_started, finished, prev_hold;
    logic [EW-1:0] obs, prev_obs, exp_v;
    n_taps = 0; n_last = 0; n_done = 0;
    stall_left = 0; stall_started = 0; finished = 0; prev_hold = 0; prev_obs = '0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(posedge clk); #1;
      if (stall_len > 0 && !stall_started && n_taps == stall_at) begin
        stall_started = 1; stall_left = stall_len;
      end
      if (stall_left > 0) begin
        tap_ready = 1'b0; stall_left--;
      end else begin
        tap_ready = ($urandom_range(99) < ready_pct);
      end
      pix_valid = poke && (n_taps < TAPS - 10);
      pix_data  = $urandom();
      wgt_we    = poke && (n_taps < TAPS - 10) && ($urandom_range(1) == 1);
      wgt_addr  = 4'($urandom_range(KH * KW - 1));
      wgt_data  = $urandom();
      @(negedge clk);
      obs = {tap_last, input_data, weight_data};
      if (tap_valid && prev_hold) begin
        total++;
        if (obs !== prev_obs) begin
          bad++;
          $display("FAIL hold_stable tap=%0d got=%h required=%h", n_taps, obs, prev_obs);
        end
      end
      if (tap_valid && tap_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_tap tap=%0d got=%h required=none", n_taps, obs);
        end else begin
          exp_v = exp_q.pop_front();
          if (obs !== exp_v) begin
            bad++;
            $display("FAIL tap_data tap=%0d got=%h required=%h", n_taps, obs, exp_v);
          end
        end
        if (n_taps < KH * KW) obs_first[n_taps] = obs;
        n_taps++;
        if (tap_last) n_last++;
      end
      prev_hold = tap_valid && !tap_ready;
      prev_obs  = obs;
      if (frame_done) n_done++;
      if (frame_done || (stop_at > 0 && n_taps == stop_at)) begin
        finished = 1;
        break;
      end
    end
    tap_ready = 1'b0; pix_valid = 1'b0; wgt_we = 1'b0;
    total++;
    if (!finished) begin
      bad++;
      $display("FAIL collect_timeout got=%0d taps required=%0d", n_taps, TAPS);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0; pix_valid = 1'b0; pix_data = '0; wgt_we = 1'b0; wgt_addr = '0;
    wgt_data = '0; tap_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({tap_valid, tap_last, frame_done} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b required=000", {tap_valid, tap_last, frame_done});
    end
    total++;
    if (input_data !== '0 || weight_data !== '0) begin
      bad++; $display("FAIL reset_data got=%h/%h required=0/0", input_data, weight_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (pix_ready !== 1'b1 || dbg_state !== ST_LOAD) begin
      bad++; $display("FAIL reset_release got=%b/%0d required=1/%0d", pix_ready, dbg_state, ST_LOAD);
    end
  endtask

  task automatic test_basic_frame();
    int n_taps, n_last, n_done;
    logic [EW-1:0] want [4];
    int idx [4];
    load_weights(0);
    load_frame(0);
    total++;
    if (pix_ready !== 1'b0 || dbg_state !== ST_EMIT) begin
      bad++; $display("FAIL emit_entry got=%b/%0d required=0/%0d", pix_ready, dbg_state, ST_EMIT);
    end
    collect(100, 0, 0, 0, 0, n_taps, n_last, n_done);
    total++;
    if (n_taps !== TAPS || n_last !== NWIN || n_done !== 1) begin
      bad++; $display("FAIL basic_counts got=%0d/%0d/%0d required=%0d/%0d/1", n_taps, n_last, n_done, TAPS, NWIN);
    end
    for (int kx = 0; kx < KW; kx++) begin
      total++;
      if (obs_first[kx][2*DATA_W-1:DATA_W] !== '0) begin
        bad++; $display("FAIL first_win_pad kx=%0d got=%h required=0", kx, obs_first[kx][2*DATA_W-1:DATA_W]);
      end
    end
    idx[0] = 0;  want[0] = {1'b0, 32'd0, 32'd1};
    idx[1] = 7;  want[1] = {1'b0, 32'd3, 32'd8};
    idx[2] = 13; want[2] = {1'b0, 32'd22, 32'd14};
    idx[3] = 14; want[3] = {1'b1, 32'd0, 32'd15};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_first[idx[i]] !== want[i]) begin
        bad++; $display("FAIL first_win tap=%0d got=%h required=%h", idx[i], obs_first[idx[i]], want[i]);
      end
    end
    @(posedge clk); #1;
    total++;
    if (frame_done !== 1'b0 || pix_ready !== 1'b1 || dbg_state !== ST_LOAD) begin
      bad++; $display("FAIL after_done got=%b/%b/%0d required=0/1/%0d", frame_done, pix_ready, dbg_state, ST_LOAD);
    end
  endtask

  task automatic test_stall();
    int n_taps, n_last, n_done;
    load_frame(1);
    collect(100, 100, 5, 0, 0, n_taps, n_last, n_done);
    total++;
    if (n_taps !== TAPS || n_last !== NWIN || n_done !== 1 || exp_q.size() !== 0) begin
      bad++; $display("FAIL stall_counts got=%0d/%0d/%0d left=%0d required=%0d/%0d/1 left=0",
                      n_taps, n_last, n_done, exp_q.size(), TAPS, NWIN);
    end
  endtask

  task automatic test_emit_isolation();
    int n_taps, n_last, n_done;
    load_frame(1);
    collect(100, 0, 0, 0, 1, n_taps, n_last, n_done);
    total++;
    if (n_taps !== TAPS || n_done !== 1) begin
      bad++; $display("FAIL iso_counts got=%0d/%0d required=%0d/1", n_taps, n_done, TAPS);
    end
    load_frame(1);
    collect(100, 0, 0, 0, 0, n_taps, n_last, n_done);
    total++;
    if (n_taps !== TAPS || n_last !== NWIN || exp_q.size() !== 0) begin
      bad++; $display("FAIL iso_next_counts got=%0d/%0d left=%0d required=%0d/%0d left=0",
                      n_taps, n_last, exp_q.size(), TAPS, NWIN);
    end
  endtask

  task automatic test_reset_mid_emit();
    int n_taps, n_last, n_done;
    load_frame(1);
    collect(100, 0, 0, 200, 0, n_taps, n_last, n_done);
    #2;
    total++;
    if (tap_valid !== 1'b1) begin
      bad++; $display("FAIL pre_reset_valid got=%b required=1", tap_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (tap_valid !== 1'b0 || dbg_state !== ST_LOAD || pix_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset got=%b/%0d/%b required=0/%0d/1", tap_valid, dbg_state, pix_ready, ST_LOAD);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    load_weights(0);
    load_frame(0);
    collect(100, 0, 0, 0, 0, n_taps, n_last, n_done);
    total++;
    if (obs_first[0] !== {1'b0, 32'd0, 32'd1} || obs_first[14] !== {1'b1, 32'd0, 32'd15}) begin
      bad++; $display("FAIL reload_first got=%h/%h required=%h/%h", obs_first[0], obs_first[14],
                      {1'b0, 32'd0, 32'd1}, {1'b1, 32'd0, 32'd15});
    end
    total++;
    if (n_taps !== TAPS || n_done !== 1) begin
      bad++; $display("FAIL reload_counts got=%0d/%0d required=%0d/1", n_taps, n_done, TAPS);
    end
  endtask

  task automatic test_back_to_back();
    int n_taps, n_last, n_done;
    load_weights(1);
    for (int f = 0; f < 2; f++) begin
      load_frame(1);
      collect(50, 0, 0, 0, 0, n_taps, n_last, n_done);
      total++;
      if (n_taps !== TAPS || n_last !== NWIN || n_done !== 1 || exp_q.size() !== 0) begin
        bad++; $display("FAIL b2b_counts frame=%0d got=%0d/%0d/%0d left=%0d required=%0d/%0d/1 left=0",
                        f, n_taps, n_last, n_done, exp_q.size(), TAPS, NWIN);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_frame();
    test_stall();
    test_emit_isolation();
    test_reset_mid_emit();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
